// File: rtl/processador_uc.sv
// Multicycle control unit: sequences fetch/decode/execute for the datapath,
// runs req/ack handshakes with both memories and latches faults until reset.
module processador_uc #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        IR_load,
    output logic        PC_load,
    output logic        rf_we,
    output logic        JAL,
    output logic        JALR,
    output logic [1:0]  OP_MEM_I,
    output logic [1:0]  ULAop,
    output logic        halted,
    output logic [1:0]  fault_code,
    output logic [31:0] instret
);

    localparam int unsigned CW = $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_WB, S_MEMADDR, S_MEM, S_BRANCH, S_JUMP, S_FAULT
    } state_e;

    typedef enum logic [2:0] {
        K_OP, K_OPIMM, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_JALR, K_AUIPC
    } kind_e;

    typedef enum logic [1:0] {
        F_NONE = 2'b00, F_ILLEGAL = 2'b01, F_IMEM = 2'b10, F_DMEM = 2'b11
    } fault_e;

    state_e        state_q, state_d;
    kind_e         kind_q, kind_d;
    fault_e        fault_q, fault_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   instret_q, instret_d;

    logic       imem_req_c, dmem_req_c, dmem_we_c, ir_load_c, pc_load_c, rf_we_c;
    logic       jal_c, jalr_c, halted_c;
    logic [1:0] op_mem_i_c, ulaop_c;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        kind_d     = kind_q;
        fault_d    = fault_q;
        cnt_d      = cnt_q;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        ir_load_c  = 1'b0;
        pc_load_c  = 1'b0;
        rf_we_c    = 1'b0;
        jal_c      = 1'b0;
        jalr_c     = 1'b0;
        halted_c   = 1'b0;
        op_mem_i_c = 2'b00;
        ulaop_c    = 2'b00;

        case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ack) begin
                    ir_load_c = 1'b1;
                    state_d   = S_DECODE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_FAULT;
                    fault_d = F_IMEM;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DECODE: begin
                case (opcode)
                    OPC_OP:     begin kind_d = K_OP;     state_d = S_EXEC;    end
                    OPC_OPIMM:  begin kind_d = K_OPIMM;  state_d = S_EXEC;    end
                    OPC_LOAD:   begin kind_d = K_LOAD;   state_d = S_MEMADDR; end
                    OPC_STORE:  begin kind_d = K_STORE;  state_d = S_MEMADDR; end
                    OPC_BRANCH: begin kind_d = K_BRANCH; state_d = S_BRANCH;  end
                    OPC_JAL:    begin kind_d = K_JAL;    state_d = S_JUMP;    end
                    OPC_JALR:   begin kind_d = K_JALR;   state_d = S_JUMP;    end
                    OPC_AUIPC:  begin kind_d = K_AUIPC;  state_d = S_JUMP;    end
                    default: begin
                        state_d = S_FAULT;
                        fault_d = F_ILLEGAL;
                    end
                endcase
            end
            S_EXEC, S_WB: begin
                ulaop_c    = 2'b10;
                op_mem_i_c = (kind_q == K_OPIMM) ? 2'b10 : 2'b00;
                if (state_q == S_WB) begin
                    rf_we_c   = 1'b1;
                    pc_load_c = 1'b1;
                    state_d   = S_FETCH;
                    cnt_d     = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEMADDR: begin
                op_mem_i_c = (kind_q == K_LOAD) ? 2'b01 : 2'b10;
                state_d    = S_MEM;
                cnt_d      = '0;
            end
            S_MEM: begin
                op_mem_i_c = (kind_q == K_LOAD) ? 2'b01 : 2'b10;
                dmem_req_c = 1'b1;
                dmem_we_c  = (kind_q == K_STORE);
                if (dmem_ack) begin
                    pc_load_c = 1'b1;
                    rf_we_c   = (kind_q == K_LOAD);
                    state_d   = S_FETCH;
                    cnt_d     = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_FAULT;
                    fault_d = F_DMEM;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_BRANCH: begin
                ulaop_c   = 2'b01;
                pc_load_c = 1'b1;
                state_d   = S_FETCH;
                cnt_d     = '0;
            end
            S_JUMP: begin
                op_mem_i_c = 2'b11;
                rf_we_c    = 1'b1;
                pc_load_c  = 1'b1;
                jal_c      = (kind_q == K_JAL);
                jalr_c     = (kind_q == K_JALR);
                state_d    = S_FETCH;
                cnt_d      = '0;
            end
            S_FAULT: begin
                halted_c = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
                cnt_d   = '0;
            end
        endcase

        instret_d = pc_load_c ? instret_q + 32'd1 : instret_q;
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is sampled at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            kind_q    <= K_OP;
            fault_q   <= F_NONE;
            cnt_q     <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            fault_q   <= fault_d;
            cnt_q     <= cnt_d;
            instret_q <= instret_d;
        end
    end

    // Outputs read 0 throughout the reset cycle, whatever state the flops still hold.
    always_comb begin
        imem_req   = imem_req_c & ~reset;
        dmem_req   = dmem_req_c & ~reset;
        dmem_we    = dmem_we_c  & ~reset;
        IR_load    = ir_load_c  & ~reset;
        PC_load    = pc_load_c  & ~reset;
        rf_we      = rf_we_c    & ~reset;
        JAL        = jal_c      & ~reset;
        JALR       = jalr_c     & ~reset;
        halted     = halted_c   & ~reset;
        OP_MEM_I   = reset ? 2'b00 : op_mem_i_c;
        ULAop      = reset ? 2'b00 : ulaop_c;
        fault_code = reset ? 2'b00 : fault_q;
        instret    = reset ? 32'd0 : instret_q;
    end

endmodule

// File: tb/tb_processador_uc.sv
// Directed bench for processador_uc: each cycle pushes the expected output
// vector into a scoreboard queue and pops it when the outputs are sampled.
module tb_processador_uc;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BAD    = 7'b1111111;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_load;
        logic       pc_load;
        logic       rf_we;
        logic       jal;
        logic       jalr;
        logic [1:0] op_mem_i;
        logic [1:0] ulaop;
        logic       halted;
        logic [1:0] fault_code;
    } out_t;

    logic        clk;
    logic        reset;
    logic [6:0]  opcode;
    logic        imem_ack, dmem_ack;
    logic        imem_req, dmem_req, dmem_we, IR_load, PC_load, rf_we, JAL, JALR;
    logic [1:0]  OP_MEM_I, ULAop;
    logic        halted;
    logic [1:0]  fault_code;
    logic [31:0] instret;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sb_instret = '0;
    out_t        exp_q[$];

    processador_uc #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .IR_load(IR_load), .PC_load(PC_load), .rf_we(rf_we),
        .JAL(JAL), .JALR(JALR), .OP_MEM_I(OP_MEM_I), .ULAop(ULAop),
        .halted(halted), .fault_code(fault_code), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic out_t e_zero();
        out_t r = '0;
        return r;
    endfunction

    function automatic out_t e_fetch(input logic ack);
        out_t r = '0;
        r.imem_req = 1'b1;
        r.ir_load  = ack;
        return r;
    endfunction

    function automatic out_t e_exec(input logic imm);
        out_t r = '0;
        r.ulaop    = 2'b10;
        r.op_mem_i = imm ? 2'b10 : 2'b00;
        return r;
    endfunction

    function automatic out_t e_wb(input logic imm);
        out_t r = e_exec(imm);
        r.rf_we   = 1'b1;
        r.pc_load = 1'b1;
        return r;
    endfunction

    function automatic out_t e_maddr(input logic load);
        out_t r = '0;
        r.ulaop    = 2'b00;
        r.op_mem_i = load ? 2'b01 : 2'b10;
        return r;
    endfunction

    function automatic out_t e_mem(input logic load, input logic ack);
        out_t r = e_maddr(load);
        r.dmem_req = 1'b1;
        r.dmem_we  = ~load;
        r.pc_load  = ack;
        r.rf_we    = ack & load;
        return r;
    endfunction

    function automatic out_t e_branch();
        out_t r = '0;
        r.ulaop   = 2'b01;
        r.pc_load = 1'b1;
        return r;
    endfunction

    function automatic out_t e_jump(input logic jal, input logic jalr);
        out_t r = '0;
        r.op_mem_i = 2'b11;
        r.rf_we    = 1'b1;
        r.pc_load  = 1'b1;
        r.jal      = jal;
        r.jalr     = jalr;
        return r;
    endfunction

    function automatic out_t e_fault(input logic [1:0] code);
        out_t r = '0;
        r.halted     = 1'b1;
        r.fault_code = code;
        return r;
    endfunction

    // One clock cycle: drive just after the edge, sample well before the next one.
    task automatic step(input string tag, input logic rst, input logic ia, input logic da,
                        input logic [6:0] op, input out_t exp);
        out_t o, e;
        @(posedge clk);
        #1;
        reset    = rst;
        imem_ack = ia;
        dmem_ack = da;
        opcode   = op;
        exp_q.push_back(exp);
        #3;
        o.imem_req   = imem_req;
        o.dmem_req   = dmem_req;
        o.dmem_we    = dmem_we;
        o.ir_load    = IR_load;
        o.pc_load    = PC_load;
        o.rf_we      = rf_we;
        o.jal        = JAL;
        o.jalr       = JALR;
        o.op_mem_i   = OP_MEM_I;
        o.ulaop      = ULAop;
        o.halted     = halted;
        o.fault_code = fault_code;
        e = exp_q.pop_front();
        check({tag, " outputs"}, 32'(o), 32'(e));
        check({tag, " instret"}, instret, rst ? 32'd0 : sb_instret);
        if (rst) sb_instret = '0;
        else if (e.pc_load) sb_instret = sb_instret + 32'd1;
    endtask

    initial begin
        reset    = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        opcode   = '0;

        // Reset: everything low even with acks asserted.
        step("rst0", 1, 1, 1, OPC_OP, e_zero());
        step("rst1", 1, 0, 0, OPC_OP, e_zero());

        // OP with immediate ack; acks during DECODE are ignored.
        step("op fetch",  0, 1, 0, OPC_OP, e_fetch(1));
        step("op decode", 0, 1, 1, OPC_OP, e_zero());
        step("op exec",   0, 0, 0, OPC_OP, e_exec(0));
        step("op wb",     0, 0, 0, OPC_OP, e_wb(0));

        // OP-IMM with two fetch waits; opcode garbage after DECODE is ignored.
        step("opi fetch w0", 0, 0, 0, OPC_OPIMM, e_fetch(0));
        step("opi fetch w1", 0, 0, 0, OPC_OPIMM, e_fetch(0));
        step("opi fetch",    0, 1, 0, OPC_OPIMM, e_fetch(1));
        step("opi decode",   0, 0, 0, OPC_OPIMM, e_zero());
        step("opi exec",     0, 0, 0, OPC_BAD,   e_exec(1));
        step("opi wb",       0, 0, 0, OPC_LOAD,  e_wb(1));

        // LOAD with dmem_ack three cycles late.
        step("ld fetch",  0, 1, 0, OPC_LOAD, e_fetch(1));
        step("ld decode", 0, 0, 0, OPC_LOAD, e_zero());
        step("ld maddr",  0, 0, 0, OPC_LOAD, e_maddr(1));
        for (int i = 0; i < 3; i++) step("ld mem wait", 0, 0, 0, OPC_LOAD, e_mem(1, 0));
        step("ld mem ack", 0, 0, 1, OPC_LOAD, e_mem(1, 1));

        // STORE with one wait; imem_ack during MEM is ignored.
        step("st fetch",    0, 1, 0, OPC_STORE, e_fetch(1));
        step("st decode",   0, 0, 0, OPC_STORE, e_zero());
        step("st maddr",    0, 0, 0, OPC_STORE, e_maddr(0));
        step("st mem wait", 0, 1, 0, OPC_STORE, e_mem(0, 0));
        step("st mem ack",  0, 0, 1, OPC_STORE, e_mem(0, 1));

        // Reset pulsed while a load waits in MEM, with the ack arriving in the reset cycle.
        step("rm fetch",  0, 1, 0, OPC_LOAD, e_fetch(1));
        step("rm decode", 0, 0, 0, OPC_LOAD, e_zero());
        step("rm maddr",  0, 0, 0, OPC_LOAD, e_maddr(1));
        step("rm mem w0", 0, 0, 0, OPC_LOAD, e_mem(1, 0));
        step("rm mem w1", 0, 0, 0, OPC_LOAD, e_mem(1, 0));
        step("rm reset",  1, 0, 1, OPC_LOAD, e_zero());
        step("rm refetch", 0, 0, 0, OPC_LOAD, e_fetch(0));

        // BRANCH, JAL, JALR, AUIPC back-to-back, 3 cycles each.
        step("br fetch",    0, 1, 0, OPC_BRANCH, e_fetch(1));
        step("br decode",   0, 0, 0, OPC_BRANCH, e_zero());
        step("br exec",     0, 0, 0, OPC_BRANCH, e_branch());
        step("jal fetch",   0, 1, 0, OPC_JAL,    e_fetch(1));
        step("jal decode",  0, 0, 0, OPC_JAL,    e_zero());
        step("jal jump",    0, 0, 0, OPC_JAL,    e_jump(1, 0));
        step("jalr fetch",  0, 1, 0, OPC_JALR,   e_fetch(1));
        step("jalr decode", 0, 0, 0, OPC_JALR,   e_zero());
        step("jalr jump",   0, 0, 0, OPC_JALR,   e_jump(0, 1));
        step("aui fetch",   0, 1, 0, OPC_AUIPC,  e_fetch(1));
        step("aui decode",  0, 0, 0, OPC_AUIPC,  e_zero());
        step("aui jump",    0, 0, 0, OPC_AUIPC,  e_jump(0, 0));
        check("instret after four jumps", sb_instret, 32'd4);

        // Ack on the 16th fetch cycle wins over the timeout.
        for (int i = 0; i < 15; i++) step("to16 fetch wait", 0, 0, 0, OPC_BRANCH, e_fetch(0));
        step("to16 fetch ack", 0, 1, 0, OPC_BRANCH, e_fetch(1));
        step("to16 decode",    0, 0, 0, OPC_BRANCH, e_zero());
        step("to16 branch",    0, 0, 0, OPC_BRANCH, e_branch());

        // No imem_ack at all: fault after 16 fetch cycles, late acks ignored.
        for (int i = 0; i < 16; i++) step("ito fetch wait", 0, 0, 0, OPC_OP, e_fetch(0));
        for (int i = 0; i < 3; i++) step("ito fault", 0, 1, 1, OPC_OP, e_fault(2'b10));
        step("ito reset", 1, 0, 0, OPC_OP, e_zero());

        // Illegal opcode: sticky fault, no fetch for 20 cycles.
        step("ill fetch",  0, 1, 0, OPC_BAD, e_fetch(1));
        step("ill decode", 0, 0, 0, OPC_BAD, e_zero());
        for (int i = 0; i < 20; i++) step("ill fault", 0, 1, 0, OPC_OP, e_fault(2'b01));
        step("ill reset",   1, 0, 0, OPC_OP, e_zero());
        step("ill refetch", 0, 0, 0, OPC_OP, e_fetch(0));

        // Data memory never answers a store: fault code 11.
        step("dto fetch",  0, 1, 0, OPC_STORE, e_fetch(1));
        step("dto decode", 0, 0, 0, OPC_STORE, e_zero());
        step("dto maddr",  0, 0, 0, OPC_STORE, e_maddr(0));
        for (int i = 0; i < 16; i++) step("dto mem wait", 0, 0, 0, OPC_STORE, e_mem(0, 0));
        for (int i = 0; i < 2; i++) step("dto fault", 0, 0, 1, OPC_STORE, e_fault(2'b11));
        step("dto reset",  1, 0, 0, OPC_OP, e_zero());
        step("end fetch",  0, 1, 0, OPC_OP, e_fetch(1));
        step("end decode", 0, 0, 0, OPC_OP, e_zero());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
